// File: rtl/ex_div_unit.sv
// RV32M iterative divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration array.
module ex_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic            is_rem_q;
    logic            neg_q;
    logic [XLEN-1:0] result_q;

    logic            sgn_op;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] spec_val;
    logic [XLEN-1:0] rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] fix_val;

    always_comb begin
        sgn_op   = ~op[0];
        div0     = (opb == '0);
        ovf      = sgn_op && (opa == SMIN) && (opb == '1);
        a_abs    = (sgn_op && opa[XLEN-1]) ? -opa : opa;
        b_abs    = (sgn_op && opb[XLEN-1]) ? -opb : opb;
        spec_val = div0 ? (op[1] ? opa : '1) : (op[1] ? '0 : SMIN);
        // 33-bit compare of {rem,dvd msb} against divisor; the carried-out rem msb forces ge
        rem_sh   = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
        ge       = rem_q[XLEN-1] || (rem_sh >= dvs_q);
        rem_d    = ge ? (rem_sh - dvs_q) : rem_sh;
        fix_val  = is_rem_q ? rem_q : dvd_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        is_rem_q <= op[1];
                        neg_q    <= sgn_op && (op[1] ? opa[XLEN-1] : (opa[XLEN-1] ^ opb[XLEN-1]));
                        dvd_q    <= a_abs;
                        dvs_q    <= b_abs;
                        rem_q    <= '0;
                        cnt_q    <= CW'(XLEN - 1);
                        if (div0 || ovf) begin
                            result_q <= spec_val;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    // quotient bits shift into the vacated dividend LSBs
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[XLEN-2:0], ge};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    result_q <= neg_q ? -fix_val : fix_val;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: directed vector table, corner-case sequences and randomized ops
// checked against an arithmetic reference model.
module tb_ex_div_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] opa   = '0;
    logic [31:0] opb   = '0;
    logic        ready, busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_div_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .op(op), .opa(opa), .opb(opb),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Present an op on the falling edge; returns #1 after the accepting edge (cycle T+1).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        opa = $urandom; opb = $urandom;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bsy);
        lat = lat0;
        bsy = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) bsy++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic count_done(input int n, output int nd);
        nd = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) nd++;
        end
    endtask

    initial begin
        int lat, bsy, nd;
        logic [1:0]  ro;
        logic [31:0] ra, rb, prev;

        vt.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         34});
        vt.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          34});
        vt.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
        vt.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34});
        vt.push_back('{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          34});
        vt.push_back('{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  34});
        vt.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34});
        vt.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vt.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          1});
        vt.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vt.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vt.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34});
        vt.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34});

        // reset and idle
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("idle_ready",  {31'd0, ready}, 32'd1);
            chk("idle_busy",   {31'd0, busy},  32'd0);
            chk("idle_done",   {31'd0, done},  32'd0);
            chk("idle_result", result,         32'd0);
        end

        // directed table; each op after the first is issued in the previous DONE cycle
        for (int i = 0; i < vt.size(); i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            wait_done(1, lat, bsy);
            chk($sformatf("vec%0d_result", i), result, vt[i].res);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bsy), 32'(vt[i].lat - 1));
        end

        // start during CALC is ignored
        issue(2'b01, 32'hFFFF_FFFF, 32'd1);
        repeat (3) begin @(posedge clock); #1; end
        @(negedge clock);
        op = 2'b01; opa = 32'd5; opb = 32'd0; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(5, lat, bsy);
        chk("calc_start_latency", 32'(lat), 32'd34);
        chk("calc_start_result", result, 32'hFFFF_FFFF);
        count_done(40, nd);
        chk("calc_start_extra_done", 32'(nd), 32'd0);
        chk("result_hold", result, 32'hFFFF_FFFF);

        // flush mid-CALC, with a simultaneous start that must be dropped
        prev = result;
        issue(2'b00, 32'd1000, 32'd10);
        count_done(9, nd);
        @(negedge clock);
        flush = 1'b1; start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd0;
        @(posedge clock);
        #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_no_done_before", 32'(nd), 32'd0);
        chk("flush_ready", {31'd0, ready}, 32'd1);
        chk("flush_busy",  {31'd0, busy},  32'd0);
        chk("flush_done",  {31'd0, done},  32'd0);
        chk("flush_result_kept", result, prev);
        issue(2'b01, 32'd9, 32'd3);
        wait_done(1, lat, bsy);
        chk("post_flush_latency", 32'(lat), 32'd34);
        chk("post_flush_result", result, 32'd3);

        // flush in the DONE cycle keeps that pulse and returns to IDLE
        @(negedge clock);
        flush = 1'b1;
        chk("flush_in_done_pulse", {31'd0, done}, 32'd1);
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush_in_done_idle", {31'd0, done}, 32'd0);
        chk("flush_in_done_result", result, 32'd3);

        // reset mid-operation
        issue(2'b00, 32'd1000, 32'd10);
        count_done(5, nd);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midreset_ready",  {31'd0, ready}, 32'd1);
        chk("midreset_busy",   {31'd0, busy},  32'd0);
        chk("midreset_result", result,         32'd0);
        count_done(40, nd);
        chk("midreset_no_done", 32'(nd), 32'd0);

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
            wait_done(1, lat, bsy);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), result, ref_res(ro, ra, rb));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(ro, ra, rb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
